// File: rtl/alu_cmp_pkg.sv
// Shared types and helpers for the RV32IM magnitude comparator.
// A compare result is one of LT/EQ/GT; wider results are built by merging slices.
package alu_cmp_pkg;

    localparam int CMP_SLICE_W = 4;

    typedef enum logic [1:0] {
        CMP_LT,
        CMP_EQ,
        CMP_GT
    } cmp_res_t;

    // The more significant slice decides unless it saw equal nibbles.
    function automatic cmp_res_t cmp_merge(input cmp_res_t upper, input cmp_res_t lower);
        return (upper == CMP_EQ) ? lower : upper;
    endfunction

endpackage

// File: rtl/alu_cmp_slice.sv
// Combinational unsigned compare of one 4-bit operand slice.
module alu_cmp_slice
    import alu_cmp_pkg::*;
(
    input  logic [CMP_SLICE_W-1:0] a,
    input  logic [CMP_SLICE_W-1:0] b,
    output cmp_res_t               res
);

    always_comb begin
        res = CMP_EQ;
        if (a > b) begin
            res = CMP_GT;
        end else if (a < b) begin
            res = CMP_LT;
        end
    end

endmodule

// File: rtl/alu_comparator_rv32im.sv
// Registered signed/unsigned magnitude comparator with one-hot G/E/L flags.
// Valid protocol: in_valid qualifies the operands at a rising edge; out_valid follows one cycle later, no backpressure.
module alu_comparator_rv32im
    import alu_cmp_pkg::*;
#(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  is_unsigned,
    input  logic [data_width-1:0] operand_A,
    input  logic [data_width-1:0] operand_B,
    output logic                  out_valid,
    output logic                  Greater,
    output logic                  Equal,
    output logic                  Less
);

    localparam int num_slices  = data_width / CMP_SLICE_W;
    localparam int tree_levels = $clog2(num_slices);
    localparam int num_leaves  = 1 << tree_levels;

    // Heap-ordered merge tree: node n has children 2n (lower) and 2n+1 (upper).
    cmp_res_t tree [1:2*num_leaves-1];

    for (genvar k = 0; k < num_leaves; k++) begin : g_leaf
        if (k < num_slices) begin : g_slice
            alu_cmp_slice u_slice (
                .a   (operand_A[k*CMP_SLICE_W +: CMP_SLICE_W]),
                .b   (operand_B[k*CMP_SLICE_W +: CMP_SLICE_W]),
                .res (tree[num_leaves+k])
            );
        end else begin : g_pad
            // Padding above the top slice reads as equal so it never overrides.
            assign tree[num_leaves+k] = CMP_EQ;
        end
    end

    for (genvar n = 1; n < num_leaves; n++) begin : g_node
        assign tree[n] = cmp_merge(tree[2*n+1], tree[2*n]);
    end

    cmp_res_t final_res;
    logic     sign_a;
    logic     sign_b;

    assign sign_a = operand_A[data_width-1];
    assign sign_b = operand_B[data_width-1];

    // With differing sign bits, the negative operand is the smaller one.
    always_comb begin
        final_res = tree[1];
        if (!is_unsigned && (sign_a != sign_b)) begin
            final_res = sign_a ? CMP_LT : CMP_GT;
        end
    end

    logic greater_d;
    logic equal_d;
    logic less_d;

    always_comb begin
        greater_d = 1'b0;
        equal_d   = 1'b0;
        less_d    = 1'b0;
        case (final_res)
            CMP_GT:  greater_d = 1'b1;
            CMP_LT:  less_d    = 1'b1;
            default: equal_d   = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Greater   <= 1'b0;
            Equal     <= 1'b0;
            Less      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Greater <= greater_d;
                Equal   <= equal_d;
                Less    <= less_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_comparator_rv32im.sv
// Scoreboard bench for alu_comparator_rv32im: directed vectors plus a random sweep.
module tb_alu_comparator_rv32im;

    localparam int W = 32;
    localparam logic [2:0] R_G = 3'b100;
    localparam logic [2:0] R_E = 3'b010;
    localparam logic [2:0] R_L = 3'b001;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         is_unsigned;
    logic [W-1:0] operand_A;
    logic [W-1:0] operand_B;
    logic         out_valid;
    logic         Greater;
    logic         Equal;
    logic         Less;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [2:0] exp_q[$];
    int         exp_cyc_q[$];

    alu_comparator_rv32im #(.data_width(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .is_unsigned (is_unsigned),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .out_valid   (out_valid),
        .Greater     (Greater),
        .Equal       (Equal),
        .Less        (Less)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drivers
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic u, input logic [2:0] exp);
        @(posedge clk);
        #1;
        operand_A   = a;
        operand_B   = b;
        is_unsigned = u;
        in_valid    = 1'b1;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + 1);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
        if (a == b) return R_E;
        if (u) return (a > b) ? R_G : R_L;
        return ($signed(a) > $signed(b)) ? R_G : R_L;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("one_hot", 32'($countones({Greater, Equal, Less})), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                logic [2:0] e;
                int         ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("flags_gel", 32'({Greater, Equal, Less}), 32'(e));
                check("latency_cycle", 32'(cyc), 32'(ec));
            end
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         ru;
        int           wait_cnt;

        rst_n       = 1'b0;
        in_valid    = 1'b1;
        is_unsigned = 1'b0;
        operand_A   = 32'd5;
        operand_B   = 32'd3;

        // Reset held with live operands: outputs stay clear
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", 32'({out_valid, Greater, Equal, Less}), 32'd0);
        end
        #2;
        rst_n = 1'b1;
        exp_q.push_back(R_G);
        exp_cyc_q.push_back(cyc + 1);
        #1;
        check("post_release_pre_edge", 32'({out_valid, Greater, Equal, Less}), 32'd0);

        // Signed directed, back-to-back
        issue(32'd5,                32'd3,                1'b0, R_G);
        issue(-32'sd655,            32'd3,                1'b0, R_L);
        issue(32'd255,              -32'sd343,            1'b0, R_G);
        issue(-32'sd11,             -32'sd346,            1'b0, R_G);
        issue(32'd8995,             32'd5433,             1'b0, R_G);
        issue(32'd7,                32'd7,                1'b0, R_E);

        // Mode contrast and boundaries
        issue(32'hFFFF_FFFF,        32'd1,                1'b0, R_L);
        issue(32'hFFFF_FFFF,        32'd1,                1'b1, R_G);
        issue(32'h8000_0000,        32'h7FFF_FFFF,        1'b0, R_L);
        issue(32'h8000_0000,        32'h7FFF_FFFF,        1'b1, R_G);
        issue(32'hFFFF_FFFF,        32'h0000_0000,        1'b0, R_L);
        issue(32'hFFFF_FFFF,        32'h0000_0000,        1'b1, R_G);
        issue(32'h0000_0000,        32'hFFFF_FFFF,        1'b0, R_G);
        issue(32'hDEAD_BEEF,        32'hDEAD_BEEF,        1'b1, R_E);
        issue(32'h8000_0000,        32'h8000_0000,        1'b0, R_E);
        issue(32'h1234_5678,        32'h1234_5679,        1'b1, R_L);
        issue(32'h1000_0000,        32'h0FFF_FFFF,        1'b1, R_G);
        issue(32'h00F0_0000,        32'h000F_FFFF,        1'b0, R_G);
        issue(32'hFFFF_FFFE,        32'hFFFF_FFFF,        1'b0, R_L);

        // Hold: flags keep the last result while out_valid drops
        issue(32'd5, 32'd3, 1'b0, R_G);
        idle_cycle();
        repeat (3) begin
            idle_cycle();
            @(negedge clk);
            check("hold_valid_flags", 32'({out_valid, Greater, Equal, Less}), 32'({1'b0, R_G}));
        end

        // Random sweep against the $signed/$unsigned reference
        for (int i = 0; i < 2000; i++) begin
            ra = $urandom();
            rb = (i % 8 == 0) ? ra : $urandom();
            if (i % 16 == 5) rb = ra ^ (32'h1 << $urandom_range(0, 31));
            ru = 1'($urandom_range(0, 1));
            issue(ra, rb, ru, model(ra, rb, ru));
        end
        idle_cycle();
        repeat (2) @(negedge clk);

        // Asynchronous reset while a result is showing
        issue(32'd7, 32'd9, 1'b1, R_L);
        @(posedge clk);
        #2;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        check("async_reset_clear", 32'({out_valid, Greater, Equal, Less}), 32'd0);
        @(negedge clk);
        check("async_reset_hold", 32'({out_valid, Greater, Equal, Less}), 32'd0);
        #2;
        rst_n = 1'b1;
        issue(32'h8000_0000, 32'd0, 1'b0, R_L);
        issue(32'h8000_0000, 32'd0, 1'b1, R_G);
        idle_cycle();

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
